// File: rtl/arb_pkg.sv
// Shared types, default constants and byte-lane helpers for the memory-port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_DATA,
        OWN_FETCH
    } arb_owner_t;

    localparam int ARB_MEM_LATENCY = 4;
    localparam int ARB_STARVE_MAX  = 4;

    // Lane k carries word bits [8k+7:8k].
    typedef logic [3:0][7:0] byte_lanes_t;

    function automatic byte_lanes_t word_to_lanes(input logic [31:0] word);
        byte_lanes_t lanes;
        for (int k = 0; k < 4; k++) begin
            lanes[k] = word[8*k +: 8];
        end
        return lanes;
    endfunction

    function automatic logic [31:0] lanes_to_word(input byte_lanes_t lanes);
        logic [31:0] word;
        for (int k = 0; k < 4; k++) begin
            word[8*k +: 8] = lanes[k];
        end
        return word;
    endfunction

endpackage

// File: rtl/arb_access_timer.sv
// Loadable down-counter that times one memory access; last is high while the count is zero.
module arb_access_timer #(
    parameter int MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int TW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(MEM_LATENCY - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between fetch refills and the data cache, with data
// priority bounded by a starvation limit so fetch always makes progress.
module mem_port_arbiter import arb_pkg::*; #(
    parameter int MEM_LATENCY = ARB_MEM_LATENCY,
    parameter int STARVE_MAX  = ARB_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            ifu_req,
    input  logic [31:0]     ifu_addr,
    output logic            ifu_done,
    output logic [31:0]     ifu_rdata,
    input  logic            dc_req,
    input  logic            dc_we,
    input  logic [31:0]     dc_addr,
    input  logic [31:0]     dc_wdata,
    output logic            dc_done,
    output logic [31:0]     dc_rdata,
    output logic [31:0]     mem_addr,
    output logic [3:0][7:0] mem_data_in,
    input  logic [3:0][7:0] mem_data_out,
    output logic            mem_write_en
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    arb_state_t    state;
    arb_state_t    next_state;
    arb_owner_t    owner;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [SW-1:0] starve_cnt;
    logic          grant;
    logic          grant_fetch;
    logic          last;
    logic          access_end;

    arb_access_timer #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_timer (
        .clk  (clk),
        .rst_b(rst_b),
        .load (grant),
        .en   (state == ACCESS),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        grant       = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (ifu_req || dc_req) begin
                    grant       = 1'b1;
                    grant_fetch = ifu_req && (!dc_req || (starve_cnt == STARVE_LIMIT));
                    next_state  = ACCESS;
                end
            end
            ACCESS: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The strobe is gated by reset so a reset landing in the final cycle never commits a write.
    assign access_end   = (state == ACCESS) && last;
    assign mem_write_en = access_end && we_q && rst_b;
    assign mem_data_in  = word_to_lanes(wdata_q);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            owner      <= OWN_DATA;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_addr   <= '0;
            starve_cnt <= '0;
            ifu_done   <= 1'b0;
            dc_done    <= 1'b0;
            ifu_rdata  <= '0;
            dc_rdata   <= '0;
        end else begin
            ifu_done <= access_end && (owner == OWN_FETCH);
            dc_done  <= access_end && (owner == OWN_DATA);
            if (grant) begin
                if (grant_fetch) begin
                    owner      <= OWN_FETCH;
                    mem_addr   <= ifu_addr;
                    we_q       <= 1'b0;
                    starve_cnt <= '0;
                end else begin
                    owner      <= OWN_DATA;
                    mem_addr   <= dc_addr;
                    we_q       <= dc_we;
                    wdata_q    <= dc_wdata;
                    starve_cnt <= ifu_req ? starve_cnt + 1'b1 : '0;
                end
            end
            if (access_end && !we_q) begin
                if (owner == OWN_FETCH) begin
                    ifu_rdata <= lanes_to_word(mem_data_out);
                end else begin
                    dc_rdata <= lanes_to_word(mem_data_out);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: a transaction-level arbiter model and a bench-side memory check the
// default build; a second MEM_LATENCY=1 build gets directed back-to-back and drop checks.
module tb_mem_port_arbiter;

    localparam int LAT    = 4;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_b    = 1'b0;
    logic            ifu_req  = 1'b0;
    logic [31:0]     ifu_addr = '0;
    logic            dc_req   = 1'b0;
    logic            dc_we    = 1'b0;
    logic [31:0]     dc_addr  = '0;
    logic [31:0]     dc_wdata = '0;
    logic            ifu_done, dc_done, mem_write_en;
    logic [31:0]     ifu_rdata, dc_rdata, mem_addr;
    logic [3:0][7:0] mem_data_in, mem_data_out;

    logic            f_rst_b    = 1'b0;
    logic            f_ifu_req  = 1'b0;
    logic [31:0]     f_ifu_addr = '0;
    logic            f_dc_req   = 1'b0;
    logic            f_dc_we    = 1'b0;
    logic [31:0]     f_dc_addr  = '0;
    logic [31:0]     f_dc_wdata = '0;
    logic            f_ifu_done, f_dc_done, f_mem_write_en;
    logic [31:0]     f_ifu_rdata, f_dc_rdata, f_mem_addr;
    logic [3:0][7:0] f_mem_data_in, f_mem_data_out;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_MAX(STARVE)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_rdata(ifu_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(STARVE)) u_dut_fast (
        .clk(clk), .rst_b(f_rst_b),
        .ifu_req(f_ifu_req), .ifu_addr(f_ifu_addr), .ifu_done(f_ifu_done), .ifu_rdata(f_ifu_rdata),
        .dc_req(f_dc_req), .dc_we(f_dc_we), .dc_addr(f_dc_addr), .dc_wdata(f_dc_wdata),
        .dc_done(f_dc_done), .dc_rdata(f_dc_rdata),
        .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in), .mem_data_out(f_mem_data_out),
        .mem_write_en(f_mem_write_en)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234_5678 : ((a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F);
    endfunction

    // Bench-side memory: 128 aliased words, written only through the DUT's pins.
    logic [31:0] dev_arr [128];
    logic        dev_written [128] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem_write_en) begin
            dev_arr[mem_addr[6:0]]     <= mem_data_in;
            dev_written[mem_addr[6:0]] <= 1'b1;
        end
    end

    assign mem_data_out   = dev_written[mem_addr[6:0]] ? dev_arr[mem_addr[6:0]] : init_word(mem_addr);
    assign f_mem_data_out = init_word(f_mem_addr);

    int checks = 0;
    int passes = 0;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        dq[$];
    logic [31:0] iq[$];

    // Transaction-level model of the shared port.
    int          cyc = 0;
    logic        m_busy = 1'b0;
    logic        m_fetch = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    int          m_wcyc = 0, m_dcyc = 0, m_starve = 0;
    logic [31:0] model_arr [128];
    logic        model_written [128] = '{default: 1'b0};

    logic        dc_done_seen = 1'b0, ifu_done_seen = 1'b0, rst_prev_low = 1'b1;
    int          rst_cycles = 0;
    bit          reset_at_write = 1'b0;
    bit          random_mode = 1'b0;
    logic [15:0] order_bits = '0;
    int          order_n = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_written[a[6:0]] ? model_arr[a[6:0]] : init_word(a);
    endfunction

    task automatic push_dc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        dq.push_back(t);
    endtask

    task automatic apply_stimulus();
        txn_t t;
        if (rst_prev_low) begin
            dc_req  = 1'b0;
            ifu_req = 1'b0;
        end
        if (dc_done_seen)  dc_req  = 1'b0;
        if (ifu_done_seen) ifu_req = 1'b0;
        if (random_mode) begin
            if (dq.size() == 0 && $urandom_range(0, 99) < 45)
                push_dc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom());
            if (iq.size() == 0 && $urandom_range(0, 99) < 45)
                iq.push_back(32'($urandom_range(0, 127)));
        end
        if (!dc_req && dq.size() > 0) begin
            t = dq.pop_front();
            dc_req = 1'b1; dc_we = t.we; dc_addr = t.addr; dc_wdata = t.wdata;
        end
        if (!ifu_req && iq.size() > 0) begin
            ifu_addr = iq.pop_front();
            ifu_req  = 1'b1;
        end
        if (rst_cycles > 0) begin
            rst_b = 1'b0;
            rst_cycles--;
        end else if (reset_at_write && m_busy && m_we && cyc == m_wcyc) begin
            rst_b = 1'b0;
            reset_at_write = 1'b0;
        end else begin
            rst_b = 1'b1;
        end
    endtask

    task automatic model_step();
        logic            exp_we, exp_dd, exp_id, idle_now;
        logic [3:0][7:0] exp_lanes;
        idle_now = !m_busy;
        exp_we = m_busy && m_we && (cyc == m_wcyc) && rst_b;
        exp_dd = m_busy && !m_fetch && (cyc == m_dcyc);
        exp_id = m_busy && m_fetch && (cyc == m_dcyc);
        check_output("pulses{we,dc_done,ifu_done}", {mem_write_en, dc_done, ifu_done}, {exp_we, exp_dd, exp_id});
        if (rst_prev_low) begin
            check_output("reset_mem_addr", mem_addr, 32'h0);
            check_output("reset_mem_data_in", mem_data_in, 32'h0);
            check_output("reset_rdata{ifu,dc}", {ifu_rdata, dc_rdata}, 64'h0);
        end
        if (exp_we) begin
            for (int k = 0; k < 4; k++) exp_lanes[k] = m_wdata[8*k +: 8];
            check_output("write_addr", mem_addr, m_addr);
            check_output("write_lanes", mem_data_in, exp_lanes);
            model_arr[m_addr[6:0]]     = m_wdata;
            model_written[m_addr[6:0]] = 1'b1;
        end
        if (exp_dd && !m_we) check_output("dc_rdata", dc_rdata, m_rdata);
        if (exp_id)          check_output("ifu_rdata", ifu_rdata, m_rdata);
        if ((dc_done || ifu_done) && order_n < 16) begin
            order_bits[order_n] = ifu_done;
            order_n++;
        end
        if (exp_dd || exp_id) m_busy = 1'b0;
        if (idle_now && rst_b && (dc_req || ifu_req)) begin
            m_fetch = ifu_req && (!dc_req || m_starve == STARVE);
            if (m_fetch) begin
                m_starve = 0; m_addr = ifu_addr; m_we = 1'b0;
            end else begin
                m_starve = ifu_req ? m_starve + 1 : 0;
                m_addr = dc_addr; m_we = dc_we; m_wdata = dc_wdata;
            end
            m_busy  = 1'b1;
            m_wcyc  = cyc + LAT;
            m_dcyc  = cyc + LAT + 1;
            m_rdata = model_read(m_addr);
        end
        if (!rst_b) begin
            m_busy = 1'b0;
            m_starve = 0;
        end
        dc_done_seen  = dc_done;
        ifu_done_seen = ifu_done;
        rst_prev_low  = !rst_b;
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        apply_stimulus();
        @(negedge clk);
        model_step();
    endtask

    task automatic drain(input string tag, input int budget);
        int  n = 0;
        logic pending;
        pending = 1'b1;
        while (pending && n < budget) begin
            step();
            n++;
            pending = (dq.size() > 0) || (iq.size() > 0) || dc_req || ifu_req || m_busy;
        end
        check_output({tag, "_drained"}, pending, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][7:0] exp_lanes;
        rst_cycles = 3;
        repeat (4) step();

        $display("[TB] single data write");
        push_dc(1'b1, 32'h100, 32'hDEAD_BEEF);
        drain("write", 40);

        $display("[TB] single fetch read");
        iq.push_back(32'h40);
        drain("fetch", 40);

        $display("[TB] simultaneous requests");
        order_n = 0;
        push_dc(1'b0, 32'h21, 32'h0);
        iq.push_back(32'h22);
        drain("simul", 60);
        check_output("simul_order", {order_n[7:0], order_bits[1:0]}, {8'd2, 2'b10});

        $display("[TB] starvation");
        order_n = 0;
        for (int i = 0; i < 8; i++) push_dc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom());
        iq.push_back(32'h30);
        iq.push_back(32'h31);
        drain("starve", 200);
        check_output("starve_order", {order_n[7:0], order_bits[9:0]}, {8'd10, 10'b10_0001_0000});

        $display("[TB] reset during final write cycle");
        push_dc(1'b1, 32'h55, 32'hCAFE_F00D);
        reset_at_write = 1'b1;
        drain("reset_write", 40);
        check_output("reset_fired", reset_at_write, 1'b0);
        push_dc(1'b0, 32'h55, 32'h0);
        drain("after_reset", 40);

        $display("[TB] random traffic");
        random_mode = 1'b1;
        repeat (400) step();
        random_mode = 1'b0;
        drain("random", 200);

        $display("[TB] latency-1 build");
        @(posedge clk); #1;
        f_rst_b = 1'b1;
        @(posedge clk); #1;
        f_ifu_req  = 1'b1;
        f_ifu_addr = 32'h10;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check_output("fast_ifu_done", f_ifu_done, (k % 3) == 2);
            check_output("fast_no_write", f_mem_write_en, 1'b0);
            if ((k % 3) == 2) check_output("fast_ifu_rdata", f_ifu_rdata, init_word(f_ifu_addr));
            @(posedge clk); #1;
            if ((k % 3) == 2) f_ifu_addr = f_ifu_addr + 32'h1;
        end
        f_ifu_req  = 1'b0;
        f_dc_req   = 1'b1;
        f_dc_we    = 1'b1;
        f_dc_addr  = 32'h22;
        f_dc_wdata = $urandom();
        for (int k = 0; k < 4; k++) exp_lanes[k] = f_dc_wdata[8*k +: 8];
        @(posedge clk); #1;
        f_dc_req = 1'b0;
        @(negedge clk);
        check_output("fast_drop_we", f_mem_write_en, 1'b1);
        check_output("fast_drop_addr", f_mem_addr, 32'h22);
        check_output("fast_drop_lanes", f_mem_data_in, exp_lanes);
        @(negedge clk);
        check_output("fast_drop_done", f_dc_done, 1'b1);
        @(negedge clk);
        check_output("fast_done_width", f_dc_done, 1'b0);
        @(posedge clk); #1;
        f_dc_req  = 1'b1;
        f_dc_we   = 1'b0;
        f_dc_addr = 32'h33;
        @(posedge clk); #1;
        f_dc_req = 1'b0;
        @(negedge clk);
        check_output("fast_read_no_write", f_mem_write_en, 1'b0);
        @(negedge clk);
        check_output("fast_read_done", f_dc_done, 1'b1);
        check_output("fast_read_rdata", f_dc_rdata, init_word(32'h33));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between the instruction-fetch refill path and the data cache. Each access is one 32-bit word and takes a fixed number of cycles; only one access is in flight at a time. The block sits between the two requesters and the memory pins (`mem_addr`, `mem_data_in`, `mem_data_out`, `mem_write_en`). Data-cache requests have priority, and a starvation limit guarantees fetch progress.

## Interface
Parameters:
- `MEM_LATENCY`, default 4: cycles the address (and write data) are held on the memory port per access; must be ≥1.
- `STARVE_MAX`, default 4: consecutive data grants allowed while fetch is waiting; the next grant goes to fetch. Must be ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_b` in 1: synchronous active-low reset.
- `ifu_req` in 1: fetch requests a read. Must be held, with `ifu_addr` stable, until `ifu_done`.
- `ifu_addr` in 32: fetch word address.
- `ifu_done` out 1: one-cycle pulse; `ifu_rdata` is valid in that cycle.
- `ifu_rdata` out 32: fetched word.
- `dc_req` in 1: data cache requests an access. Must be held, with `dc_addr`, `dc_we` and `dc_wdata` stable, until `dc_done`.
- `dc_we` in 1: 1 = write, 0 = read.
- `dc_addr` in 32: data word address.
- `dc_wdata` in 32: write data.
- `dc_done` out 1: one-cycle pulse; for reads, `dc_rdata` is valid in that cycle.
- `dc_rdata` out 32: read word.
- `mem_addr` out 32: memory address.
- `mem_data_in` out 8×4: write data to memory; element k = word bits [8k+7:8k].
- `mem_data_out` in 8×4: read data from memory, same byte mapping.
- `mem_write_en` out 1: memory write strobe.

## Operation
State machine: IDLE → ACCESS → DONE → IDLE.

- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant data unless `starve_cnt == STARVE_MAX`; in that case grant fetch.
  - On a grant: latch the owner, address, `we` and wdata into registers; load `timer = MEM_LATENCY-1`; go to ACCESS.
- **ACCESS**
  - `mem_addr` and `mem_data_in` are driven from the latched registers.
  - `timer` decrements each cycle. When it reaches 0:
    - `mem_write_en` = latched `we` in that cycle only.
    - For a read, capture `mem_data_out` into the rdata register.
    - Go to DONE.
- **DONE**
  - Pulse the owner's `*_done` for one cycle; the owner's rdata register holds the captured word.
  - Both requests are ignored in this cycle; the FSM returns to IDLE.
- **Starvation counter (`starve_cnt`, 0..STARVE_MAX)**
  - On a data grant while `ifu_req` is high: increment.
  - On a data grant while `ifu_req` is low: clear to 0.
  - On a fetch grant: clear to 0.
- **Fetch writes:** fetch never writes; its latched `we` is forced to 0.
- **Idle outputs:** `mem_write_en` = 0. `mem_addr` and `mem_data_in` hold their last latched values.
- **Requester drops its request mid-access:** the access still completes, the write is still committed, and `*_done` still pulses.
- **Reset mid-access:** the FSM returns to IDLE and no write strobe is issued, even if reset lands in the final ACCESS cycle.

## Timing
- **Reset values:**
  - state = IDLE, `timer` = 0, `starve_cnt` = 0, owner = data.
  - `mem_addr` = 0, `mem_data_in` = all 0, `mem_write_en` = 0.
  - `ifu_done` = 0, `dc_done` = 0, `ifu_rdata` = 0, `dc_rdata` = 0.
- **Latency:** request sampled high in IDLE at edge T → ACCESS for cycles T+1..T+MEM_LATENCY → `*_done` high in cycle T+MEM_LATENCY+1.
- **Throughput:** the next grant is sampled in the IDLE cycle at T+MEM_LATENCY+2. One access every MEM_LATENCY+2 cycles.
- **Done pulse:** `*_done` is registered and high for exactly one cycle. Requesters drop `req` on the edge ending that cycle; a `req` still high in the following IDLE cycle is a new request.
- **Read sampling:** `mem_data_out` is sampled only on the edge ending the last ACCESS cycle. Memory must present read data within MEM_LATENCY cycles of the address.
- **Write commit:** the write commits on the same edge; `mem_addr` and `mem_data_in` are stable throughout ACCESS.
- **Case MEM_LATENCY = 1:** ACCESS lasts one cycle, which is both the first and the last.

## Structure
- **Package `arb_pkg`:**
  - `arb_state_t` enum: IDLE, ACCESS, DONE.
  - `arb_owner_t` enum: OWN_DATA, OWN_FETCH.
  - Default constants: `ARB_MEM_LATENCY = 4`, `ARB_STARVE_MAX = 4`.
  - Byte-lane pack/unpack functions between 32-bit words and the 8×4 arrays.
- **Sub-module `arb_access_timer`:**
  - Loadable down-counter sized `$clog2(MEM_LATENCY)` bits (minimum 1).
  - Inputs: `load`, `en`. Output: `last` (count == 0).
  - Uses the same `clk`/`rst_b`.
- Everything else lives in `mem_port_arbiter`.

## Test plan
1. **Single data write.** `dc_req=1`, `dc_we=1`, `dc_addr=0x100`, `dc_wdata=0xDEADBEEF`, sampled at T.
   - `mem_write_en` high only in cycle T+4, with `mem_addr=0x100` and `mem_data_in={EF,BE,AD,DE}` (elements 0..3).
   - `dc_done` high in cycle T+5.
2. **Single fetch read.** `ifu_req`, `ifu_addr=0x40`; memory returns 0x12345678.
   - `ifu_done` high at T+5 with `ifu_rdata=0x12345678`.
   - `mem_write_en` stays 0 throughout.
3. **Simultaneous requests.** `dc_req` and `ifu_req` high in the same IDLE cycle.
   - Data is granted first; fetch is granted in the next IDLE cycle (T+6).
4. **Starvation.** Both requests held continuously, STARVE_MAX=4.
   - Grant order: D, D, D, D, F, D, D, D, D, F.
   - `starve_cnt` clears after each F.
5. **Reset mid-write.** `rst_b=0` during the final ACCESS cycle of a write.
   - No `mem_write_en` pulse and no `dc_done`.
   - All outputs at reset values; a new request after reset completes normally.
6. **MEM_LATENCY=1 build, request dropped mid-access.**
   - Back-to-back reads complete in 3 cycles each.
   - A `dc_req` dropped mid-access still produces a `dc_done` pulse.
